// File: rtl/fetch_unit_if.sv
// Instruction-memory port for fetch_unit: one-outstanding request channel
// (valid/ready) plus an unconditional response strobe.
interface fetch_unit_if #(
  parameter int unsigned WordSize = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [WordSize-1:0] imem_addr;
  logic                imem_rsp_valid;
  logic [WordSize-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// buffers a word across a stall and squashes wrong-path fetches on redirect.
module fetch_unit #(
  parameter int unsigned         WordSize  = 32,
  parameter logic [WordSize-1:0] ResetAddr = '0,
  parameter logic [WordSize-1:0] NopInst   = WordSize'(32'h0000_0013)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_branch_taken,
  input  logic [WordSize-1:0] i_npc,
  input  logic                i_stall,
  fetch_unit_if.master        imem,
  output logic [WordSize-1:0] o_pc,
  output logic                o_if_valid,
  output logic [WordSize-1:0] o_if_pc,
  output logic [WordSize-1:0] o_if_pc4,
  output logic [WordSize-1:0] o_if_inst
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WordSize-1:0] r_pc, w_pc_nxt;
  logic [WordSize-1:0] r_req_pc, w_req_pc_nxt;
  logic                r_drop, w_drop_nxt;
  logic [WordSize-1:0] r_buf_inst, r_buf_pc;
  logic                r_if_valid;
  logic [WordSize-1:0] r_if_pc, r_if_pc4, r_if_inst;

  logic                w_req_valid;
  logic                w_buf_load;
  logic                w_if_load;
  logic [WordSize-1:0] w_if_inst_new;
  logic [WordSize-1:0] w_if_pc_new;
  logic [WordSize-1:0] w_target;

  assign w_target = i_npc & ~WordSize'(3);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_req_pc_nxt  = r_req_pc;
    w_drop_nxt    = r_drop;
    w_req_valid   = 1'b0;
    w_buf_load    = 1'b0;
    w_if_load     = 1'b0;
    w_if_inst_new = imem.imem_rsp_data;
    w_if_pc_new   = r_req_pc;

    unique case (r_state)
      S_FETCH: begin
        w_req_valid = 1'b1;
        if (imem.imem_req_ready) begin
          w_req_pc_nxt = r_pc;
          w_state_nxt  = S_WAIT;
          // The accepted request carried the old PC; its response must be dropped.
          w_drop_nxt   = i_branch_taken;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (r_drop || i_branch_taken) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end else begin
            w_pc_nxt = r_req_pc + WordSize'(4);
            if (i_stall) begin
              w_buf_load  = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_if_load   = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end
        end else if (i_branch_taken) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_branch_taken || !i_stall) begin
          w_state_nxt   = S_FETCH;
          w_if_load     = !i_branch_taken;
          w_if_inst_new = r_buf_inst;
          w_if_pc_new   = r_buf_pc;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase

    if (i_branch_taken) begin
      w_pc_nxt = w_target;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= ResetAddr;
      r_req_pc   <= ResetAddr;
      r_drop     <= 1'b0;
      r_buf_inst <= NopInst;
      r_buf_pc   <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_inst  <= NopInst;
    end else begin
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
      if (w_buf_load) begin
        r_buf_inst <= imem.imem_rsp_data;
        r_buf_pc   <= r_req_pc;
      end
      // Redirect flushes IF/ID even under stall; otherwise stall freezes it.
      if (i_branch_taken) begin
        r_if_valid <= 1'b0;
        r_if_inst  <= NopInst;
      end else if (!i_stall) begin
        if (w_if_load) begin
          r_if_valid <= 1'b1;
          r_if_inst  <= w_if_inst_new;
          r_if_pc    <= w_if_pc_new;
          r_if_pc4   <= w_if_pc_new + WordSize'(4);
        end else begin
          r_if_valid <= 1'b0;
          r_if_inst  <= NopInst;
        end
      end
    end
  end

  assign imem.imem_req_valid = w_req_valid & ~i_rst;
  assign imem.imem_addr      = r_pc;
  assign o_pc                = r_pc;
  assign o_if_valid          = r_if_valid;
  assign o_if_pc             = r_if_pc;
  assign o_if_pc4            = r_if_pc4;
  assign o_if_inst           = r_if_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// wrap-around and asynchronous-reset sequences.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] npc = '0;
  logic        stall = 1'b0;
  logic [31:0] pc, if_pc, if_pc4, if_inst;
  logic        if_valid;

  fetch_unit_if #(.WordSize(32)) imem ();

  fetch_unit #(
    .WordSize (32),
    .ResetAddr(32'h0000_0000),
    .NopInst  (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_branch_taken(branch_taken),
    .i_npc         (npc),
    .i_stall       (stall),
    .imem          (imem),
    .o_pc          (pc),
    .o_if_valid    (if_valid),
    .o_if_pc       (if_pc),
    .o_if_pc4      (if_pc4),
    .o_if_inst     (if_inst)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] npc;
    logic        stl;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_ifpc4;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] d, logic br,
                              logic [31:0] n, logic st, logic rqv, logic [31:0] a,
                              logic ifv, logic [31:0] ipc, logic [31:0] ipc4,
                              logic [31:0] inst);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = d; v.br = br; v.npc = n; v.stl = st;
    v.e_rqv = rqv; v.e_addr = a; v.e_ifv = ifv; v.e_ifpc = ipc;
    v.e_ifpc4 = ipc4; v.e_inst = inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] d,
                       input logic br, input logic [31:0] n, input logic st);
    imem.imem_req_ready = rdy;
    imem.imem_rsp_valid = rv;
    imem.imem_rsp_data  = d;
    branch_taken        = br;
    npc                 = n;
    stall               = st;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, '0, 0, '0, 0);

    //            rdy rv data          br npc           st | rqv addr          ifv if_pc         if_pc4        inst
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,          0, 32'h0,        32'h0,        NOP));
    vecs.push_back(mk(0, 1, 32'hA0,       0, 32'h0,        0,  0, 32'h0,          0, 32'h0,        32'h0,        NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h4,          1, 32'h0,        32'h4,        32'hA0));
    vecs.push_back(mk(0, 1, 32'hA1,       0, 32'h0,        0,  0, 32'h4,          0, 32'h0,        32'h4,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8,          1, 32'h4,        32'h8,        32'hA1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 1, 32'hA2,       0, 32'h0,        1,  0, 32'h8,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1,  0, 32'hC,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1,  0, 32'hC,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1,  0, 32'hC,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  0, 32'hC,          0, 32'h4,        32'h8,        NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'hC,          1, 32'h8,        32'hC,        32'hA2));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h103,      0,  0, 32'hC,          0, 32'h8,        32'hC,        NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h100,        0, 32'h8,        32'hC,        NOP));
    vecs.push_back(mk(0, 1, 32'hDEAD,     0, 32'h0,        0,  0, 32'h100,        0, 32'h8,        32'hC,        NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h100,        0, 32'h8,        32'hC,        NOP));
    vecs.push_back(mk(0, 1, 32'hE0,       0, 32'h0,        0,  0, 32'h100,        0, 32'h8,        32'hC,        NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h104,        1, 32'h100,      32'h104,      32'hE0));
    vecs.push_back(mk(0, 1, 32'hE1,       0, 32'h0,        1,  0, 32'h104,        1, 32'h100,      32'h104,      32'hE0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h200,      1,  0, 32'h108,        1, 32'h100,      32'h104,      32'hE0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h200,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h300,      0,  1, 32'h200,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h400,      0,  0, 32'h300,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(0, 1, 32'hF0,       0, 32'h0,        0,  0, 32'h400,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h400,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(0, 1, 32'h77,       0, 32'h0,        0,  0, 32'h400,        0, 32'h100,      32'h104,      NOP));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h404,        1, 32'h400,      32'h404,      32'h77));

    // Reset state with clock running and reset held.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    chk("rst.pc",        pc,                     32'h0);
    chk("rst.if_valid",  {31'b0, if_valid},      32'h0);
    chk("rst.if_pc",     if_pc,                  32'h0);
    chk("rst.if_pc4",    if_pc4,                 32'h0);
    chk("rst.if_inst",   if_inst,                NOP);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].br, vecs[i].npc, vecs[i].stl);
      #1;
      chk($sformatf("v%0d.req_valid", i), {31'b0, imem.imem_req_valid}, {31'b0, vecs[i].e_rqv});
      chk($sformatf("v%0d.addr", i),      imem.imem_addr,               vecs[i].e_addr);
      chk($sformatf("v%0d.pc", i),        pc,                           vecs[i].e_addr);
      chk($sformatf("v%0d.if_valid", i),  {31'b0, if_valid},            {31'b0, vecs[i].e_ifv});
      chk($sformatf("v%0d.if_pc", i),     if_pc,                        vecs[i].e_ifpc);
      chk($sformatf("v%0d.if_pc4", i),    if_pc4,                       vecs[i].e_ifpc4);
      chk($sformatf("v%0d.if_inst", i),   if_inst,                      vecs[i].e_inst);
      @(negedge clk);
    end

    // Redirect to the top word (low bits masked), then fetch across the wrap.
    drive(0, 0, '0, 1, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    drive(1, 0, '0, 0, '0, 0);
    #1;
    chk("wrap.req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    chk("wrap.addr",      imem.imem_addr,               32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 1, 32'h55, 0, '0, 0);
    @(negedge clk);
    drive(1, 0, '0, 0, '0, 0);
    #1;
    chk("wrap.if_valid", {31'b0, if_valid}, 32'h1);
    chk("wrap.if_pc",    if_pc,             32'hFFFF_FFFC);
    chk("wrap.if_pc4",   if_pc4,            32'h0);
    chk("wrap.if_inst",  if_inst,           32'h55);
    chk("wrap.pc",       pc,                32'h0);
    @(negedge clk);
    drive(0, 1, 32'h66, 0, '0, 0);
    @(negedge clk);
    drive(1, 0, '0, 0, '0, 0);
    #1;
    chk("post.addr",   imem.imem_addr, 32'h4);
    chk("post.if_pc4", if_pc4,         32'h4);
    @(negedge clk);

    // Asynchronous reset mid-WAIT: clears before any clock edge.
    drive(0, 0, '0, 0, '0, 0);
    #1;
    chk("midwait.req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    chk("midwait.pc",        pc,                           32'h4);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.pc",       pc,                32'h0);
    chk("arst.if_valid", {31'b0, if_valid}, 32'h0);
    chk("arst.if_pc",    if_pc,             32'h0);
    chk("arst.if_pc4",   if_pc4,            32'h0);
    chk("arst.if_inst",  if_inst,           NOP);
    @(negedge clk);
    #1;
    chk("arst.req_valid_held", {31'b0, imem.imem_req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst.req_valid_first", {31'b0, imem.imem_req_valid}, 32'h1);
    chk("arst.addr_first",      imem.imem_addr,               32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
